// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
// Holds the FSM state type, request-type encoding and default ack timeout.
package sys_bus_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  typedef enum logic {
    ReqRead  = 1'b0,
    ReqWrite = 1'b1
  } req_type_e;

  localparam int unsigned TmoDefault = 32;
  localparam int unsigned CntW       = 6;

  // A write strobe dominates: wen and ren together count as a write.
  function automatic req_type_e req_type(input logic wen);
    return wen ? ReqWrite : ReqRead;
  endfunction

endpackage

// File: rtl/sys_bus_req_latch.sv
// Per-master request capture: latches one request and holds it until cleared.
// A new pulse arriving in the same cycle as the clear is captured.
module sys_bus_req_latch
  import sys_bus_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wen_i,
  input  logic          ren_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [SW-1:0] sel_i,
  input  logic          clr_i,
  output logic          pending_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic [SW-1:0] sel_o,
  output req_type_e     type_o
);

  logic          pending_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] sel_q;
  req_type_e     type_q;
  logic          capture;

  assign capture = (wen_i | ren_i) & (~pending_q | clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      type_q    <= ReqRead;
    end else if (capture) begin
      pending_q <= 1'b1;
      addr_q    <= addr_i;
      wdata_q   <= wdata_i;
      sel_q     <= sel_i;
      type_q    <= req_type(wen_i);
    end else if (clr_i) begin
      pending_q <= 1'b0;
    end
  end

  assign pending_o = pending_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign sel_o     = sel_q;
  assign type_o    = type_q;

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin arbiter onto a single-outstanding system bus slave,
// with a per-transaction ack timeout that completes the request with an error.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned SW  = DW / 8,
  parameter int unsigned TMO = TmoDefault
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_wen_i,
  input  logic          m0_ren_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_wen_i,
  input  logic          m1_ren_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_wen_o,
  output logic          s_ren_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_err_i,
  input  logic          s_ack_i,
  output logic          busy_o,
  output logic          gnt_o
);

  logic [1:0]    in_wen, in_ren, pend, clr;
  logic [AW-1:0] in_addr  [2];
  logic [DW-1:0] in_wdata [2];
  logic [SW-1:0] in_sel   [2];
  logic [AW-1:0] lat_addr [2];
  logic [DW-1:0] lat_wdata[2];
  logic [SW-1:0] lat_sel  [2];
  req_type_e     lat_type [2];

  assign in_wen      = {m1_wen_i, m0_wen_i};
  assign in_ren      = {m1_ren_i, m0_ren_i};
  assign in_addr[0]  = m0_addr_i;
  assign in_addr[1]  = m1_addr_i;
  assign in_wdata[0] = m0_wdata_i;
  assign in_wdata[1] = m1_wdata_i;
  assign in_sel[0]   = m0_sel_i;
  assign in_sel[1]   = m1_sel_i;

  for (genvar i = 0; i < 2; i++) begin : g_latch
    sys_bus_req_latch #(
      .AW(AW),
      .DW(DW),
      .SW(SW)
    ) u_latch (
      .clk_i    (sys_clk_i),
      .rst_i    (sys_rst_i),
      .wen_i    (in_wen[i]),
      .ren_i    (in_ren[i]),
      .addr_i   (in_addr[i]),
      .wdata_i  (in_wdata[i]),
      .sel_i    (in_sel[i]),
      .clr_i    (clr[i]),
      .pending_o(pend[i]),
      .addr_o   (lat_addr[i]),
      .wdata_o  (lat_wdata[i]),
      .sel_o    (lat_sel[i]),
      .type_o   (lat_type[i])
    );
  end

  state_e          state_q, state_d;
  logic            fav_q, gnt_q;
  logic [CntW-1:0] cnt_q;
  logic            s_wen_q, s_ren_q;
  logic [AW-1:0]   s_addr_q;
  logic [DW-1:0]   s_wdata_q;
  logic [SW-1:0]   s_sel_q;
  logic [1:0]      ack_q, err_q;
  logic [DW-1:0]   rdata_q  [2];

  logic issue, grant, contested, complete, timeout;

  assign contested = &pend;

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    grant    = fav_q;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|pend) begin
          issue   = 1'b1;
          grant   = contested ? fav_q : pend[1];
          state_d = StWait;
        end
      end
      StWait: begin
        // The slave ack is not honoured during the issue-pulse cycle itself.
        if (s_ack_i && !(s_wen_q || s_ren_q)) begin
          complete = 1'b1;
        end else if (cnt_q == CntW'(TMO - 1)) begin
          complete = 1'b1;
          timeout  = 1'b1;
        end
        if (complete) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr = complete ? (2'b01 << gnt_q) : 2'b00;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q   <= StIdle;
      fav_q     <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      s_wen_q   <= 1'b0;
      s_ren_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_wen_q <= issue && (lat_type[grant] == ReqWrite);
      s_ren_q <= issue && (lat_type[grant] == ReqRead);
      if (issue) begin
        s_addr_q  <= lat_addr[grant];
        s_wdata_q <= lat_wdata[grant];
        s_sel_q   <= lat_sel[grant];
        gnt_q     <= grant;
        cnt_q     <= '0;
        // Pointer advances only on contested grants so back-to-back pairs alternate.
        if (contested) begin
          fav_q <= ~fav_q;
        end
      end else if (state_q == StWait) begin
        cnt_q <= complete ? '0 : cnt_q + CntW'(1);
      end
      ack_q <= clr;
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= '0;
        err_q[i]   <= 1'b0;
        if (clr[i]) begin
          rdata_q[i] <= timeout ? '0 : s_rdata_i;
          err_q[i]   <= timeout | s_err_i;
        end
      end
    end
  end

  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign s_sel_o    = s_sel_q;
  assign s_wen_o    = s_wen_q;
  assign s_ren_o    = s_ren_q;
  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
  assign busy_o     = (state_q == StWait);
  assign gnt_o      = gnt_q;

endmodule
